// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//
// Purpose:
//   Sits between execute and writeback and tells Fetch how each retiring
//   instruction really behaved. It compares the actual next PC of every
//   accepted instruction with the next PC Fetch predicted for it. It then
//   emits a registered branch_update_* report for control-flow instructions
//   and for any misprediction.
//
//   After a misprediction the block enters SQUASH. In SQUASH it drops every
//   presented result until the redirect target instruction shows up.
//   Free-running branch and mispredict counters support performance monitoring.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   in_valid                     instruction result presented this cycle
//   in_pc                        PC of the presented instruction
//   in_is_branch / in_is_jump    conditional branch / unconditional jump
//   in_taken                     resolved direction (branches only)
//   in_target                    resolved branch/jump target
//   in_pred_next_pc              next PC Fetch chose after in_pc
//   branch_update_*              registered one-cycle report to Fetch
//   squash_active                high while wrong-path results are dropped
//   branch_count                 reports issued for branches/jumps
//   mispredict_count             reports flagged as mispredicted
// -----------------------------------------------------------------------------
module branch_resolve #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic             in_is_branch,
  input  logic             in_is_jump,
  input  logic             in_taken,
  input  logic [31:0]      in_target,
  input  logic [31:0]      in_pred_next_pc,
  output logic             branch_update_valid,
  output logic             branch_update_taken,
  output logic             branch_update_mispredicted,
  output logic             branch_update_unconditional,
  output logic [31:0]      branch_update_addr,
  output logic [31:0]      branch_update_target,
  output logic             squash_active,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam logic [0:0] ST_NORMAL = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      redirectPc_q, redirectPc_d;
  logic             valid_q, valid_d;
  logic             taken_q, taken_d;
  logic             mis_q, mis_d;
  logic             uncond_q, uncond_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      target_q, target_d;
  logic [CNT_W-1:0] branchCnt_q, branchCnt_d;
  logic [CNT_W-1:0] misCnt_q, misCnt_d;

  logic             takenAct;
  logic [31:0]      nextAct;
  logic             misAct;
  logic             isControl;
  logic             accept;
  logic             report;

  // Resolve the instruction's real successor. The jump flag dominates, so an
  // illegal branch+jump combination behaves like a jump.
  always_comb begin
    takenAct  = in_is_jump | (in_is_branch & in_taken);
    nextAct   = takenAct ? in_target : (in_pc + 32'd4);
    misAct    = (nextAct != in_pred_next_pc);
    isControl = in_is_branch | in_is_jump;
    // In SQUASH only the redirect target instruction gets through; it is
    // handled exactly like a NORMAL-state instruction in the same cycle.
    accept    = in_valid & ((state_q == ST_NORMAL) | (in_pc == redirectPc_q));
    report    = accept & (isControl | misAct);
  end

  // Next-state logic. Report fields change only when a new report fires, so
  // Fetch can sample the target a cycle after the valid pulse.
  always_comb begin
    state_d      = state_q;
    redirectPc_d = redirectPc_q;
    valid_d      = report;
    taken_d      = taken_q;
    mis_d        = mis_q;
    uncond_d     = uncond_q;
    addr_d       = addr_q;
    target_d     = target_q;
    branchCnt_d  = branchCnt_q;
    misCnt_d     = misCnt_q;

    if (accept) begin
      // Any accepted instruction closes an open squash window. A fresh
      // mispredict re-opens it with the new redirect target.
      state_d = misAct ? ST_SQUASH : ST_NORMAL;
      if (misAct) begin
        redirectPc_d = nextAct;
      end
    end

    if (report) begin
      taken_d  = takenAct;
      mis_d    = misAct;
      uncond_d = ~in_is_branch;
      addr_d   = in_pc;
      target_d = nextAct;
      if (isControl) begin
        branchCnt_d = branchCnt_q + 1'b1;
      end
      if (misAct) begin
        misCnt_d = misCnt_q + 1'b1;
      end
    end
  end

  // All state clears asynchronously. A reset during SQUASH therefore drops
  // both the pending redirect and any report that is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_NORMAL;
      redirectPc_q <= '0;
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      mis_q        <= 1'b0;
      uncond_q     <= 1'b0;
      addr_q       <= '0;
      target_q     <= '0;
      branchCnt_q  <= '0;
      misCnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      redirectPc_q <= redirectPc_d;
      valid_q      <= valid_d;
      taken_q      <= taken_d;
      mis_q        <= mis_d;
      uncond_q     <= uncond_d;
      addr_q       <= addr_d;
      target_q     <= target_d;
      branchCnt_q  <= branchCnt_d;
      misCnt_q     <= misCnt_d;
    end
  end

  assign branch_update_valid         = valid_q;
  assign branch_update_taken         = taken_q;
  assign branch_update_mispredicted  = mis_q;
  assign branch_update_unconditional = uncond_q;
  assign branch_update_addr          = addr_q;
  assign branch_update_target        = target_q;
  assign squash_active               = (state_q == ST_SQUASH);
  assign branch_count                = branchCnt_q;
  assign mispredict_count            = misCnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
//
// Purpose:
//   Self-checking bench for branch_resolve. It runs directed scenarios and
//   then randomized traffic. Everything is checked against a behavioural
//   reference model that tracks "which PC the pipeline is waiting for"
//   and the last report Fetch saw.
//
// Ports: none (top-level bench).
// -----------------------------------------------------------------------------
module tb_branch_resolve;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic [31:0] inPc;
  logic        inIsBranch;
  logic        inIsJump;
  logic        inTaken;
  logic [31:0] inTarget;
  logic [31:0] inPredNextPc;
  logic        updValid;
  logic        updTaken;
  logic        updMis;
  logic        updUncond;
  logic [31:0] updAddr;
  logic [31:0] updTarget;
  logic        squashActive;
  logic [31:0] branchCount;
  logic [31:0] mispredictCount;

  int checkCount;
  int passCount;

  // Reference model: the PC we are waiting for (if any) and what Fetch last saw.
  bit          waitingForRedirect;
  logic [31:0] awaitedPc;
  bit          modelValid;
  bit          modelTaken;
  bit          modelMis;
  bit          modelUncond;
  logic [31:0] modelAddr;
  logic [31:0] modelTarget;
  logic [31:0] modelBranches;
  logic [31:0] modelMispredicts;

  branch_resolve #(.CNT_W(32)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .in_valid                    (inValid),
    .in_pc                       (inPc),
    .in_is_branch                (inIsBranch),
    .in_is_jump                  (inIsJump),
    .in_taken                    (inTaken),
    .in_target                   (inTarget),
    .in_pred_next_pc             (inPredNextPc),
    .branch_update_valid         (updValid),
    .branch_update_taken         (updTaken),
    .branch_update_mispredicted  (updMis),
    .branch_update_unconditional (updUncond),
    .branch_update_addr          (updAddr),
    .branch_update_target        (updTarget),
    .squash_active               (squashActive),
    .branch_count                (branchCount),
    .mispredict_count            (mispredictCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // The true successor of an instruction: a jump always goes to its target,
  // a taken branch likewise, everything else falls through by 4 bytes.
  function automatic logic [31:0] trueNext(input logic [31:0] pc, input bit br,
                                           input bit jmp, input bit tk,
                                           input logic [31:0] tgt);
    if (jmp || (br && tk)) return tgt;
    return pc + 32'd4;
  endfunction

  task automatic modelReset();
    waitingForRedirect = 0;
    awaitedPc          = 32'h0;
    modelValid         = 0;
    modelTaken         = 0;
    modelMis           = 0;
    modelUncond        = 0;
    modelAddr          = 32'h0;
    modelTarget        = 32'h0;
    modelBranches      = 32'h0;
    modelMispredicts   = 32'h0;
  endtask

  task automatic checkAll();
    checkOutput("valid",         64'(updValid),        64'(modelValid));
    checkOutput("squash_active", 64'(squashActive),    64'(waitingForRedirect));
    checkOutput("branch_count",  64'(branchCount),     64'(modelBranches));
    checkOutput("mispred_count", 64'(mispredictCount), 64'(modelMispredicts));
    checkOutput("addr",          64'(updAddr),         64'(modelAddr));
    checkOutput("target",        64'(updTarget),       64'(modelTarget));
    checkOutput("taken",         64'(updTaken),        64'(modelTaken));
    checkOutput("unconditional", 64'(updUncond),       64'(modelUncond));
    if (modelValid) begin
      checkOutput("mispredicted", 64'(updMis), 64'(modelMis));
    end
  endtask

  // Presents one instruction slot (or an idle slot with v=0) for one clock.
  // It then updates the model and compares every output just after the edge.
  task automatic applyStimulus(input bit v, input logic [31:0] pc, input bit br,
                               input bit jmp, input bit tk,
                               input logic [31:0] tgt, input logic [31:0] pred);
    logic [31:0] nxt;
    bit          wrong;
    inValid      = v;
    inPc         = pc;
    inIsBranch   = br;
    inIsJump     = jmp;
    inTaken      = tk;
    inTarget     = tgt;
    inPredNextPc = pred;
    @(posedge clk);
    #1;
    modelValid = 0;
    if (v && (!waitingForRedirect || pc == awaitedPc)) begin
      nxt   = trueNext(pc, br, jmp, tk, tgt);
      wrong = (nxt != pred);
      waitingForRedirect = wrong;
      if (wrong) awaitedPc = nxt;
      if (br || jmp || wrong) begin
        modelValid  = 1;
        modelTaken  = jmp || (br && tk);
        modelMis    = wrong;
        modelUncond = !br;
        modelAddr   = pc;
        modelTarget = nxt;
        if (br || jmp) modelBranches = modelBranches + 32'd1;
        if (wrong) modelMispredicts = modelMispredicts + 32'd1;
      end
    end
    checkAll();
  endtask

  task automatic idle();
    applyStimulus(0, 32'h0, 0, 0, 0, 32'h0, 32'h0);
  endtask

  // Asserts reset away from any clock edge and checks the asynchronous clear.
  task automatic pulseReset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    modelReset();
    checkAll();
    checkOutput("rst mispredicted", 64'(updMis), 64'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] pred;
    bit          br;
    bit          jmp;
    bit          tk;
    checkCount = 0;
    passCount  = 0;
    inValid = 0; inPc = 0; inIsBranch = 0; inIsJump = 0;
    inTaken = 0; inTarget = 0; inPredNextPc = 0;
    rst = 1'b1;
    modelReset();
    #12;
    checkAll();
    checkOutput("reset mispredicted", 64'(updMis), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Correct not-taken branch.
    applyStimulus(1, 32'h100, 1, 0, 0, 32'h900, 32'h104);
    checkOutput("tp1 target", 64'(updTarget), 64'h104);
    checkOutput("tp1 branch_count", 64'(branchCount), 64'd1);

    // Taken branch predicted not-taken, then the wrong path is squashed.
    applyStimulus(1, 32'h200, 1, 0, 1, 32'h80, 32'h204);
    checkOutput("tp2 squash", 64'(squashActive), 64'h1);
    checkOutput("tp2 target", 64'(updTarget), 64'h80);
    applyStimulus(1, 32'h204, 0, 0, 0, 32'h0, 32'h208);
    checkOutput("tp2 drop 204", 64'(updValid), 64'h0);
    applyStimulus(1, 32'h208, 1, 0, 1, 32'h10, 32'h20c);
    checkOutput("tp2 drop 208", 64'(branchCount), 64'd2);
    applyStimulus(1, 32'h80, 0, 0, 0, 32'h0, 32'h84);
    checkOutput("tp2 resume", 64'(squashActive), 64'h0);

    // BTB alias on a plain instruction.
    applyStimulus(1, 32'h300, 0, 0, 0, 32'h0, 32'h40);
    checkOutput("tp3 unconditional", 64'(updUncond), 64'h1);
    checkOutput("tp3 mispred_count", 64'(mispredictCount), 64'd2);
    applyStimulus(1, 32'h304, 0, 0, 0, 32'h0, 32'h308);

    // Correctly predicted JAL, then the target holds through an idle cycle.
    applyStimulus(1, 32'h10, 0, 1, 0, 32'h400, 32'h400);
    idle();
    checkOutput("tp4 target hold", 64'(updTarget), 64'h400);

    // PC wrap on a not-taken branch.
    applyStimulus(1, 32'hFFFFFFFC, 1, 0, 0, 32'h1234, 32'h0);
    checkOutput("tp5 target", 64'(updTarget), 64'h0);

    // Reset while squashing, then any PC is accepted again.
    applyStimulus(1, 32'h600, 0, 1, 0, 32'h700, 32'h604);
    pulseReset();
    applyStimulus(1, 32'h500, 0, 0, 0, 32'h0, 32'h0);
    checkOutput("tp6 accepted", 64'(updValid), 64'h1);

    // Randomized traffic. While squashing, about half the slots present the
    // awaited PC, so the squash windows actually close.
    for (int i = 0; i < 400; i++) begin
      pc  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 15) == 0) pc = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
      if (waitingForRedirect && $urandom_range(0, 1) == 1) pc = awaitedPc;
      case ($urandom_range(0, 2))
        0: begin br = 1; jmp = 0; end
        1: begin br = 0; jmp = 1; end
        default: begin br = 0; jmp = 0; end
      endcase
      tk   = 1'($urandom_range(0, 1));
      tgt  = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      pred = ($urandom_range(0, 2) != 0) ? trueNext(pc, br, jmp, tk, tgt)
                                         : {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      applyStimulus(1'($urandom_range(0, 4) != 0), pc, br, jmp, tk, tgt, pred);
      if ($urandom_range(0, 99) == 0) pulseReset();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
